clk_monitor: RTL

CLK_MONITOR -- requirements
Module: clk_monitor

---
 rtl/clk_monitor_pkg.sv | 9 +
 rtl/clk_monitor_if.sv | 23 ++
 rtl/clk_mon_ch.sv | 46 ++++
 rtl/clk_monitor.sv | 29 ++
 4 files changed

// File: rtl/clk_monitor_pkg.sv
// clk_monitor_pkg: shared state encoding and default sizing for the clock monitor
package clk_monitor_pkg;
  localparam int CNT_W_DEF = 18;
  localparam int TIMEOUT_CTR_DEF = 250_000;
  localparam int TIMEOUT_SCAN_DEF = 25_000;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
endpackage

// File: rtl/clk_monitor_if.sv
// clk_monitor_if: monitored clock inputs and per-channel tick/period/status outputs
interface clk_monitor_if import clk_monitor_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
);
  logic clk_ctr;
  logic clk_scan;
  logic ctr_tick;
  logic scan_tick;
  logic [CNT_W-1:0] ctr_period;
  logic [CNT_W-1:0] scan_period;
  logic ctr_valid;
  logic scan_valid;
  logic ctr_lost;
  logic scan_lost;
  modport slave (
    input clk_ctr, clk_scan,
    output ctr_tick, scan_tick, ctr_period, scan_period, ctr_valid, scan_valid, ctr_lost, scan_lost
  );
  modport master (
    output clk_ctr, clk_scan,
    input ctr_tick, scan_tick, ctr_period, scan_period, ctr_valid, scan_valid, ctr_lost, scan_lost
  );
endinterface

// File: rtl/clk_mon_ch.sv
// clk_mon_ch: one monitored clock -- synchronizer, edge strobe, period counter and loss detector
module clk_mon_ch import clk_monitor_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_CTR_DEF
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             src,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             lost
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  logic sync1, sync2, hist, rise, to_hit;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [1:0] state;
  assign rise = sync2 & ~hist;
  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  // A timeout larger than the counter range can never match, which disables the alarm.
  assign to_hit = !rise && (32'(cnt) == TO_LAST);
  always_ff @(posedge sysclk)
    if (rst) begin
      {sync1, sync2, hist, tick, valid, lost} <= '0;
      cnt <= '0;
      period <= '0;
      state <= ST_IDLE;
    end else begin
      {sync1, sync2, hist} <= {src, sync1, sync2};
      tick <= rise;
      cnt <= rise ? '0 : cnt_inc;
      if (rise) begin
        lost <= 1'b0;
        state <= (state == ST_IDLE) ? ST_ARMED : ST_MEASURE;
        if (state != ST_IDLE) begin
          period <= cnt_inc;
          valid <= 1'b1;
        end
      end else if (to_hit) begin
        lost <= 1'b1;
        valid <= 1'b0;
        state <= ST_IDLE;
      end
    end
endmodule

// File: rtl/clk_monitor.sv
// clk_monitor: measures period and detects loss of the control and scan clocks on sysclk
module clk_monitor import clk_monitor_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT_CTR = TIMEOUT_CTR_DEF,
  parameter int TIMEOUT_SCAN = TIMEOUT_SCAN_DEF
) (
  input logic          sysclk,
  input logic          rst,
  clk_monitor_if.slave mon
);
  clk_mon_ch #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT_CTR)) u_ctr (
    .sysclk(sysclk),
    .rst(rst),
    .src(mon.clk_ctr),
    .tick(mon.ctr_tick),
    .period(mon.ctr_period),
    .valid(mon.ctr_valid),
    .lost(mon.ctr_lost)
  );
  clk_mon_ch #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT_SCAN)) u_scan (
    .sysclk(sysclk),
    .rst(rst),
    .src(mon.clk_scan),
    .tick(mon.scan_tick),
    .period(mon.scan_period),
    .valid(mon.scan_valid),
    .lost(mon.scan_lost)
  );
endmodule
